decoder_2to4: RTL and testbench

- Registered 2-to-4 line decoder with an enable input.
- When enabled, drives exactly one of four outputs high, selected by a 2-bit code. When disabled, drives all outputs low.
- Used as a small select/strobe generator, such as a chip-select or write-enable fan-out, in synchronous datapaths.
- Output is registered: one clock of latency from inputs to outputs.

---
 rtl/decoder_2to4.sv | 44 ++++
 tb/tb_decoder_2to4.sv | 128 ++++++++++++
 2 files changed

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 line decoder with enable; one clock of latency from
// (enable, in) to (out, out_valid), optional one-cold output polarity.
module decoder_2to4 #(
   parameter bit ACTIVE_LOW_OUT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] in,
   output logic [3:0] out,
   output logic       out_valid
);

   // Output level when no line is selected (disabled or in reset).
   localparam logic [3:0] IDLE_LVL = ACTIVE_LOW_OUT ? 4'b1111 : 4'b0000;

   logic [3:0] out_d;
   logic [3:0] out_q;
   logic       valid_d;
   logic       valid_q;

   // Polarity is folded into the next-state so the flops drive the pins directly.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dec
         assign out_d[gi] = (enable && (in == 2'(gi))) ^ ACTIVE_LOW_OUT;
      end
   endgenerate

   assign valid_d = enable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= IDLE_LVL;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed bench for decoder_2to4: one active-high and one active-low instance
// share the stimulus; every sampled output is compared with hand-computed values.
module tb_decoder_2to4;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [1:0] in;
   logic [3:0] out_hi;
   logic       valid_hi;
   logic [3:0] out_lo;
   logic       valid_lo;

   int checks   = 0;
   int failures = 0;

   decoder_2to4 #(.ACTIVE_LOW_OUT(1'b0)) u_dut_hi (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in        (in),
      .out       (out_hi),
      .out_valid (valid_hi)
   );

   decoder_2to4 #(.ACTIVE_LOW_OUT(1'b1)) u_dut_lo (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in        (in),
      .out       (out_lo),
      .out_valid (valid_lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s got=%b t=%0t", tag, got, $time);
      end
   endtask

   // Compare both instances against one expected active-high pattern.
   task automatic check_all(input string tag, input logic [3:0] exp_out, input logic exp_valid);
      check({tag, ".out"},      out_hi,          exp_out);
      check({tag, ".valid"},    {3'b000, valid_hi}, {3'b000, exp_valid});
      check({tag, ".out_lo"},   out_lo,          ~exp_out);
      check({tag, ".valid_lo"}, {3'b000, valid_lo}, {3'b000, exp_valid});
   endtask

   // Apply inputs between edges, then sample 1 ns after the next rising edge.
   task automatic cyc(input string tag, input logic en, input logic [1:0] code,
                      input logic [3:0] exp_out, input logic exp_valid);
      enable = en;
      in     = code;
      @(posedge clk);
      #1;
      check_all(tag, exp_out, exp_valid);
   endtask

   logic [3:0] onehot_tbl [4];

   initial begin
      onehot_tbl[0] = 4'b0001;
      onehot_tbl[1] = 4'b0010;
      onehot_tbl[2] = 4'b0100;
      onehot_tbl[3] = 4'b1000;

      rst    = 1'b0;
      enable = 1'b1;
      in     = 2'b10;
      #1 rst = 1'b1;
      #1;
      check_all("rst_async_pre_clk", 4'b0000, 1'b0);

      // Reset held across edges overrides decoding.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_all($sformatf("rst_held%0d", i), 4'b0000, 1'b0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_all("rst_release", 4'b0100, 1'b1);

      for (int i = 0; i < 4; i++)
         cyc($sformatf("dis_in%0d", i), 1'b0, 2'(i), 4'b0000, 1'b0);

      for (int i = 0; i < 4; i++)
         cyc($sformatf("en_in%0d", i), 1'b1, 2'(i), onehot_tbl[i], 1'b1);

      // Reverse order back-to-back codes.
      cyc("b2b_in2", 1'b1, 2'd2, 4'b0100, 1'b1);
      cyc("b2b_in1", 1'b1, 2'd1, 4'b0010, 1'b1);

      cyc("tog_en1", 1'b1, 2'b11, 4'b1000, 1'b1);
      cyc("tog_en0", 1'b0, 2'b11, 4'b0000, 1'b0);
      cyc("tog_en1b", 1'b1, 2'b11, 4'b1000, 1'b1);

      // Outputs hold between edges while inputs stay stable.
      cyc("hold_a", 1'b1, 2'b01, 4'b0010, 1'b1);
      #3;
      check_all("hold_mid", 4'b0010, 1'b1);

      // Asynchronous reset pulse of 3 ns between edges.
      #1 rst = 1'b1;
      #1;
      check_all("rst_mid_async", 4'b0000, 1'b0);
      #2 rst = 1'b0;
      #1;
      check_all("rst_mid_after_release", 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      check_all("rst_mid_redecode", 4'b0010, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
